// File: rtl/lever_pkg.sv
// Shared types and arithmetic helpers for the lever position generator.
package lever_pkg;

   localparam int unsigned SAT_W  = 13;
   localparam int unsigned AXIS_W = 8;
   localparam int unsigned STEP_W = 4;

   typedef enum logic {
      LEVER_ANALOG  = 1'b0,
      LEVER_DIGITAL = 1'b1
   } lever_mode_e;

   // a + b, clipped at ceil_v; SAT_W is wide enough that the sum never wraps
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input logic [SAT_W-1:0] ceil_v);
      logic [SAT_W-1:0] s;
      s = a + b;
      return (s > ceil_v) ? ceil_v : s;
   endfunction

   // a - b, clipped at floor_v
   function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input logic [SAT_W-1:0] floor_v);
      return (a >= floor_v + b) ? (a - b) : floor_v;
   endfunction

   // Signed stick axis to unsigned lever; non-inverted means stick up = more
   function automatic logic [AXIS_W-1:0] analog_map(input logic signed [AXIS_W-1:0] s,
                                                    input logic inv);
      logic signed [AXIS_W:0] t;
      t = inv ? (9'(s) + 9'sd128) : (9'sd127 - 9'(s));
      return AXIS_W'(t);
   endfunction

endpackage

// File: rtl/lever_ctrl_if.sv
// Joystick-side inputs and lever-side outputs of lever_ctrl.
interface lever_ctrl_if
   import lever_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned WIDTH    = 8
);
   logic [CHANNELS-1:0]        mode;
   logic [CHANNELS-1:0]        auto_return;
   logic [CHANNELS-1:0]        invert;
   logic [1:0]                 rate_sel;
   logic [AXIS_W*CHANNELS-1:0] analog_in;
   logic [CHANNELS-1:0]        inc;
   logic [CHANNELS-1:0]        dec;
   logic [WIDTH*CHANNELS-1:0]  value_out;
   logic [CHANNELS-1:0]        at_max;
   logic [CHANNELS-1:0]        at_min;
   logic                       tick;

   modport master (
      output mode, auto_return, invert, rate_sel, analog_in, inc, dec,
      input  value_out, at_max, at_min, tick
   );

   modport slave (
      input  mode, auto_return, invert, rate_sel, analog_in, inc, dec,
      output value_out, at_max, at_min, tick
   );
endinterface

// File: rtl/lever_channel.sv
// One lever channel: analog map, digital ramp accumulator, bumpless mode switch.
module lever_channel
   import lever_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = 254,
   parameter int unsigned REST_VAL = 0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              i_mode,
   input  logic              i_auto_return,
   input  logic              i_invert,
   input  logic [AXIS_W-1:0] i_analog,
   input  logic              i_inc,
   input  logic              i_dec,
   input  logic              i_tick,
   input  logic [STEP_W-1:0] i_step,
   output logic [WIDTH-1:0]  o_value,
   output logic              o_at_max,
   output logic              o_at_min
);

   lever_mode_e       w_mode;
   lever_mode_e       r_mode_d;
   logic              w_mode_chg;
   logic [AXIS_W-1:0] w_u;
   logic [WIDTH-1:0]  w_wide;
   logic [WIDTH-1:0]  w_analog;
   logic [SAT_W-1:0]  w_sat;
   logic [WIDTH-1:0]  w_acc_nxt;
   logic [WIDTH-1:0]  w_val_nxt;
   logic [WIDTH-1:0]  r_acc;
   logic [WIDTH-1:0]  r_value;
   logic              r_at_max;
   logic              r_at_min;

   assign w_mode     = lever_mode_e'(i_mode);
   assign w_mode_chg = (w_mode != r_mode_d);
   assign w_u        = analog_map(i_analog, i_invert);

   // Widen by repeating the top bits so full deflection reaches all-ones
   if (WIDTH > AXIS_W) begin : g_wide
      assign w_wide = {w_u, w_u[AXIS_W-1 -: WIDTH-AXIS_W]};
   end else begin : g_narrow
      assign w_wide = w_u;
   end

   assign w_analog = (w_wide > WIDTH'(MAX_VAL)) ? WIDTH'(MAX_VAL) : w_wide;

   // Ramp step applied on a tick
   always_comb begin
      w_sat = SAT_W'(r_acc);
      if (i_inc && !i_dec) begin
         w_sat = sat_add(SAT_W'(r_acc), SAT_W'(i_step), SAT_W'(MAX_VAL));
      end else if (i_dec && !i_inc) begin
         w_sat = sat_sub(SAT_W'(r_acc), SAT_W'(i_step), '0);
      end else if (!i_inc && !i_dec && i_auto_return) begin
         if (r_acc > WIDTH'(REST_VAL)) begin
            w_sat = sat_sub(SAT_W'(r_acc), SAT_W'(i_step), SAT_W'(REST_VAL));
         end else begin
            w_sat = sat_add(SAT_W'(r_acc), SAT_W'(i_step), SAT_W'(REST_VAL));
         end
      end
   end

   // Entering digital mode takes over the current output and skips that tick
   always_comb begin
      w_acc_nxt = r_acc;
      if (w_mode_chg) begin
         w_acc_nxt = r_value;
      end else if (i_tick) begin
         w_acc_nxt = WIDTH'(w_sat);
      end
      w_val_nxt = (w_mode == LEVER_DIGITAL) ? w_acc_nxt : w_analog;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_mode_d <= w_mode;
         r_acc    <= '0;
         r_value  <= '0;
         r_at_max <= 1'b0;
         r_at_min <= 1'b1;
      end else begin
         r_mode_d <= w_mode;
         if (w_mode == LEVER_DIGITAL) begin
            r_acc <= w_acc_nxt;
         end
         r_value  <= w_val_nxt;
         r_at_max <= (w_val_nxt == WIDTH'(MAX_VAL));
         r_at_min <= (w_val_nxt == '0);
      end
   end

   assign o_value  = r_value;
   assign o_at_max = r_at_max;
   assign o_at_min = r_at_min;

endmodule

// File: rtl/lever_ctrl.sv
// Multi-channel lever generator: shared ramp prescaler plus per-channel lever_channel.
module lever_ctrl
   import lever_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned TICK_DIV = 196850,
   parameter int unsigned MAX_VAL  = 254,
   parameter int unsigned REST_VAL = 0
) (
   input  logic         clk_sys,
   input  logic         reset,
   lever_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0]          r_cnt;
   logic [CNT_W-1:0]          w_cnt_nxt;
   logic                      r_tick;
   logic [STEP_W-1:0]         w_step;
   logic [WIDTH*CHANNELS-1:0] w_value;
   logic [CHANNELS-1:0]       w_at_max;
   logic [CHANNELS-1:0]       w_at_min;

   assign w_cnt_nxt = (r_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : (r_cnt + CNT_W'(1));
   assign w_step    = STEP_W'(1) << bus.rate_sel;

   // Tick is registered from the next count so it lines up with count == TICK_DIV-1
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_tick <= (w_cnt_nxt == CNT_W'(TICK_DIV - 1));
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      lever_channel #(
         .WIDTH    (WIDTH),
         .MAX_VAL  (MAX_VAL),
         .REST_VAL (REST_VAL)
      ) u_ch (
         .clk_sys       (clk_sys),
         .reset         (reset),
         .i_mode        (bus.mode[g]),
         .i_auto_return (bus.auto_return[g]),
         .i_invert      (bus.invert[g]),
         .i_analog      (bus.analog_in[g*AXIS_W +: AXIS_W]),
         .i_inc         (bus.inc[g]),
         .i_dec         (bus.dec[g]),
         .i_tick        (r_tick),
         .i_step        (w_step),
         .o_value       (w_value[g*WIDTH +: WIDTH]),
         .o_at_max      (w_at_max[g]),
         .o_at_min      (w_at_min[g])
      );
   end

   assign bus.value_out = w_value;
   assign bus.at_max    = w_at_max;
   assign bus.at_min    = w_at_min;
   assign bus.tick      = r_tick;

endmodule

// File: tb/tb_lever_ctrl.sv
// Directed bench for lever_ctrl; a second instance with REST_VAL=10 mirrors the inputs.
module tb_lever_ctrl;

   localparam int unsigned CH = 2;
   localparam int unsigned W  = 8;
   localparam int unsigned TD = 4;
   localparam int unsigned MV = 254;

   logic clk_sys = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk_sys = ~clk_sys;

   lever_ctrl_if #(.CHANNELS(CH), .WIDTH(W)) bus0 ();
   lever_ctrl_if #(.CHANNELS(CH), .WIDTH(W)) bus1 ();

   assign bus1.mode        = bus0.mode;
   assign bus1.auto_return = bus0.auto_return;
   assign bus1.invert      = bus0.invert;
   assign bus1.rate_sel    = bus0.rate_sel;
   assign bus1.analog_in   = bus0.analog_in;
   assign bus1.inc         = bus0.inc;
   assign bus1.dec         = bus0.dec;

   lever_ctrl #(.CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD), .MAX_VAL(MV), .REST_VAL(0)) dut0 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus0)
   );

   lever_ctrl #(.CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD), .MAX_VAL(MV), .REST_VAL(10)) dut1 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus1)
   );

   task automatic step;
      @(posedge clk_sys);
      #1;
   endtask

   // Advance to the next cycle in which tick is high (bounded)
   task automatic next_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus0.tick !== 1'b1 && n < 32);
      if (bus0.tick !== 1'b1) begin
         errors++;
         checks++;
         $display("FAIL tick_timeout: no tick within %0d cycles", n);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step();
      step();
      checks++;
      if (bus0.value_out !== 16'h0000) begin
         errors++; $display("FAIL reset_value: got %h want 0000", bus0.value_out);
      end
      checks++;
      if (bus0.at_min !== 2'b11 || bus0.at_max !== 2'b00 || bus0.tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: min=%b max=%b tick=%b want 11 00 0",
                  bus0.at_min, bus0.at_max, bus0.tick);
      end
      reset = 1'b0;
   endtask

   task automatic test_analog;
      bus0.mode = 2'b00; bus0.invert = 2'b00;
      bus0.analog_in = {8'h00, 8'h80};
      checks++;
      if (bus0.value_out !== 16'h0000) begin
         errors++; $display("FAIL analog_latency: got %h want 0000", bus0.value_out);
      end
      step();
      checks++;
      if (bus0.value_out !== {8'd127, 8'd254} || bus0.at_max !== 2'b01) begin
         errors++;
         $display("FAIL analog_neg_zero: got %h max=%b want 7ffe 01", bus0.value_out, bus0.at_max);
      end
      bus0.analog_in = {8'h00, 8'h7f};
      step();
      checks++;
      if (bus0.value_out !== {8'd127, 8'd0} || bus0.at_min !== 2'b01) begin
         errors++;
         $display("FAIL analog_pos: got %h min=%b want 7f00 01", bus0.value_out, bus0.at_min);
      end
      bus0.invert = 2'b11;
      bus0.analog_in = {8'h7f, 8'h80};
      step();
      checks++;
      if (bus0.value_out !== {8'd254, 8'd0} || bus0.at_max !== 2'b10 || bus0.at_min !== 2'b01) begin
         errors++;
         $display("FAIL analog_invert: got %h max=%b min=%b want fe00 10 01",
                  bus0.value_out, bus0.at_max, bus0.at_min);
      end
   endtask

   task automatic test_ramp;
      int n;
      int exp_v;
      bus0.mode = 2'b01; bus0.inc = 2'b01; bus0.rate_sel = 2'd0;
      bus0.invert = 2'b00; bus0.analog_in = 16'h0000;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 1; k <= 257; k++) begin
         next_tick(n);
         checks++;
         if (n != 3) begin
            errors++; $display("FAIL ramp_tick_spacing: tick %0d after %0d cycles want 3", k, n);
         end
         step();
         exp_v = (k > 254) ? 254 : k;
         checks++;
         if (bus0.value_out[7:0] !== 8'(exp_v)) begin
            errors++;
            $display("FAIL ramp_value: tick %0d got %0d want %0d", k, bus0.value_out[7:0], exp_v);
         end
      end
      checks++;
      if (bus0.at_max !== 2'b01 || bus0.value_out[15:8] !== 8'd127) begin
         errors++;
         $display("FAIL ramp_sat_mixed: max=%b ch1=%0d want 01 127", bus0.at_max, bus0.value_out[15:8]);
      end
      bus0.inc = 2'b00;
   endtask

   task automatic test_sat_dec;
      int n;
      bus0.mode = 2'b00; bus0.invert = 2'b01; bus0.analog_in = {8'h00, 8'h85};
      step();
      checks++;
      if (bus0.value_out[7:0] !== 8'd5) begin
         errors++; $display("FAIL dec_preload: got %0d want 5", bus0.value_out[7:0]);
      end
      next_tick(n);
      step();
      bus0.mode = 2'b01;
      step();
      bus0.dec = 2'b01; bus0.rate_sel = 2'd3;
      checks++;
      if (bus0.value_out[7:0] !== 8'd5) begin
         errors++; $display("FAIL dec_load: got %0d want 5", bus0.value_out[7:0]);
      end
      next_tick(n);
      step();
      checks++;
      if (bus0.value_out[7:0] !== 8'd0 || bus0.at_min[0] !== 1'b1) begin
         errors++;
         $display("FAIL dec_floor: got %0d min=%b want 0 1", bus0.value_out[7:0], bus0.at_min[0]);
      end
      bus0.inc = 2'b01;
      next_tick(n);
      step();
      checks++;
      if (bus0.value_out[7:0] !== 8'd0) begin
         errors++; $display("FAIL dec_both_hold: got %0d want 0", bus0.value_out[7:0]);
      end
      bus0.inc = 2'b00; bus0.dec = 2'b00;
   endtask

   task automatic test_auto_return;
      int n;
      int exp0[6] = '{16, 12, 8, 4, 0, 0};
      int exp1[6] = '{16, 12, 10, 10, 10, 10};
      bus0.mode = 2'b00; bus0.invert = 2'b01; bus0.analog_in = {8'h00, 8'h94};
      step();
      next_tick(n);
      step();
      bus0.mode = 2'b01; bus0.auto_return = 2'b01; bus0.rate_sel = 2'd2;
      step();
      checks++;
      if (bus0.value_out[7:0] !== 8'd20 || bus1.value_out[7:0] !== 8'd20) begin
         errors++;
         $display("FAIL ret_load: got %0d/%0d want 20/20", bus0.value_out[7:0], bus1.value_out[7:0]);
      end
      for (int i = 0; i < 6; i++) begin
         next_tick(n);
         step();
         checks++;
         if (bus0.value_out[7:0] !== 8'(exp0[i]) || bus1.value_out[7:0] !== 8'(exp1[i])) begin
            errors++;
            $display("FAIL ret_step: tick %0d got %0d/%0d want %0d/%0d", i,
                     bus0.value_out[7:0], bus1.value_out[7:0], exp0[i], exp1[i]);
         end
      end
      bus0.auto_return = 2'b00;
   endtask

   task automatic test_bumpless;
      int n;
      bus0.mode = 2'b00; bus0.invert = 2'b00; bus0.rate_sel = 2'd0;
      bus0.analog_in = {8'h00, 8'he4};
      step();
      checks++;
      if (bus0.value_out[7:0] !== 8'd155) begin
         errors++; $display("FAIL bump_analog: got %0d want 155", bus0.value_out[7:0]);
      end
      next_tick(n);
      bus0.mode = 2'b01; bus0.inc = 2'b01;
      step();
      checks++;
      if (bus0.value_out[7:0] !== 8'd155 || bus0.at_max[0] !== 1'b0 || bus0.at_min[0] !== 1'b0) begin
         errors++;
         $display("FAIL bump_switch: got %0d max=%b min=%b want 155 0 0",
                  bus0.value_out[7:0], bus0.at_max[0], bus0.at_min[0]);
      end
      next_tick(n);
      step();
      checks++;
      if (bus0.value_out[7:0] !== 8'd156) begin
         errors++; $display("FAIL bump_first_step: got %0d want 156", bus0.value_out[7:0]);
      end
      bus0.inc = 2'b00;
   endtask

   task automatic test_reset_mid_ramp;
      int n;
      bus0.mode = 2'b00; bus0.invert = 2'b11; bus0.rate_sel = 2'd0;
      bus0.analog_in = {8'h48, 8'he4};
      step();
      next_tick(n);
      step();
      bus0.mode = 2'b11;
      step();
      checks++;
      if (bus0.value_out !== {8'd200, 8'd100}) begin
         errors++; $display("FAIL rst_preload: got %h want c864", bus0.value_out);
      end
      bus0.inc = 2'b11;
      next_tick(n);
      step();
      checks++;
      if (bus0.value_out !== {8'd201, 8'd101}) begin
         errors++; $display("FAIL rst_ramp: got %h want c965", bus0.value_out);
      end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (bus0.value_out !== 16'h0000 || bus0.at_min !== 2'b11 || bus0.at_max !== 2'b00) begin
         errors++;
         $display("FAIL rst_mid: got %h min=%b max=%b want 0000 11 00",
                  bus0.value_out, bus0.at_min, bus0.at_max);
      end
      for (int c = 1; c <= 3; c++) begin
         step();
         checks++;
         if (bus0.tick !== ((c == 3) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL rst_tick_phase: cycle %0d tick=%b", c, bus0.tick);
         end
      end
      step();
      checks++;
      if (bus0.value_out !== {8'd1, 8'd1}) begin
         errors++; $display("FAIL rst_restart: got %h want 0101", bus0.value_out);
      end
      bus0.inc = 2'b00;
   endtask

   initial begin
      reset = 1'b1;
      bus0.mode = '0; bus0.auto_return = '0; bus0.invert = '0;
      bus0.rate_sel = '0; bus0.analog_in = '0; bus0.inc = '0; bus0.dec = '0;
      test_reset();
      test_analog();
      test_ramp();
      test_sat_dec();
      test_auto_return();
      test_bumpless();
      test_reset_mid_ramp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
